// File: rtl/dadda_pkg.sv
// Elaboration-time helpers for the Dadda reduction tree: height sequence,
// column heights of the partial-product matrix and per-stage cell counts.
package dadda_pkg;
  localparam int MAX_WIDTH = 16;
  localparam int PP_WIDTH  = 8;

  typedef logic [PP_WIDTH-1:0][PP_WIDTH-1:0] pp_matrix_t;

  function automatic int dadda_height(int j);
    case (j)
      0: return 2;
      1: return 3;
      2: return 4;
      3: return 6;
      4: return 9;
      5: return 13;
      6: return 19;
      default: return 28;
    endcase
  endfunction

  function automatic int col_height(int c, int w);
    if (c < w) return c + 1;
    else if (c < 2*w-1) return 2*w - 1 - c;
    else return 0;
  endfunction

  function automatic int num_stages(int w);
    int n;
    n = 0;
    while (dadda_height(n) < w) n++;
    return n;
  endfunction

  function automatic int stage_target(int w, int s);
    return dadda_height(num_stages(w) - 1 - s);
  endfunction

  // what: 0 = column height entering stage s, 1 = full adders, 2 = half adders.
  // Columns are walked LSB first so carries from c-1 count toward c's target.
  function automatic int tree_info(int w, int s, int c, int what);
    int h [2*MAX_WIDTH];
    int cin, e, nf, nh, d, res;
    res = 0;
    for (int i = 0; i < 2*MAX_WIDTH; i++) h[i] = col_height(i, w);
    for (int st = 0; st <= s; st++) begin
      d   = stage_target(w, st);
      cin = 0;
      for (int col = 0; col < 2*w; col++) begin
        e  = h[col] + cin - d;
        nf = (e > 0) ? e / 2 : 0;
        nh = (e > 0) ? e % 2 : 0;
        if (st == s && col == c) res = (what == 0) ? h[col] : (what == 1) ? nf : nh;
        h[col] = h[col] - 2*nf - nh + cin;
        cin    = nf + nh;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/dadda_tree.sv
// Combinational PP generation and Dadda HA/FA reduction to two rows; low
// columns optionally OR-compressed with no carry into the exact part.
module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module dadda_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module dadda_tree import dadda_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic [2*WIDTH-1:0] row_a,
  output logic [2*WIDTH-1:0] row_b
);
  localparam int NC = 2*WIDTH;
  localparam int NS = num_stages(WIDTH);

  logic [WIDTH-1:0] raw  [NC];
  logic [WIDTH-1:0] bits [NS+1][NC];
  logic [WIDTH-1:0] cry  [NS][NC];

  for (genvar c = 0; c < NC; c++) begin : g_in
    localparam int H0 = col_height(c, WIDTH);
    localparam int LO = (c >= WIDTH) ? c - WIDTH + 1 : 0;
    for (genvar k = 0; k < WIDTH; k++) begin : g_pp
      if (k < H0) begin : g_b
        assign raw[c][k] = a[c-LO-k] & b[LO+k];
      end else begin : g_z
        assign raw[c][k] = 1'b0;
      end
    end
    // Approximated columns are kept out of the tree so no carry can leave them.
    if (c < APPROX_COLS) begin : g_apx
      assign bits[0][c] = approx_en ? '0 : raw[c];
      assign row_a[c]   = approx_en ? |raw[c] : bits[NS][c][0];
      assign row_b[c]   = approx_en ? 1'b0    : bits[NS][c][1];
    end else begin : g_ex
      assign bits[0][c] = raw[c];
      assign row_a[c]   = bits[NS][c][0];
      assign row_b[c]   = bits[NS][c][1];
    end
    logic unused_sink;
    assign unused_sink = ^bits[NS][c];
  end

  for (genvar s = 0; s < NS; s++) begin : g_stg
    for (genvar c = 0; c < NC; c++) begin : g_col
      localparam int H   = tree_info(WIDTH, s, c, 0);
      localparam int NF  = tree_info(WIDTH, s, c, 1);
      localparam int NH  = tree_info(WIDTH, s, c, 2);
      localparam int KIN = (c == 0) ? 0 : tree_info(WIDTH, s, c-1, 1) + tree_info(WIDTH, s, c-1, 2);
      localparam int P   = H - 3*NF - 2*NH;
      logic [WIDTH-1:0] sm;

      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i < NF) begin : g_fa
          dadda_fa u_fa (.a(bits[s][c][3*i]), .b(bits[s][c][3*i+1]), .ci(bits[s][c][3*i+2]),
                         .s(sm[i]), .co(cry[s][c][i]));
        end else if (i < NF + NH) begin : g_ha
          dadda_ha u_ha (.a(bits[s][c][3*NF+2*(i-NF)]), .b(bits[s][c][3*NF+2*(i-NF)+1]),
                         .s(sm[i]), .co(cry[s][c][i]));
        end else begin : g_nc
          assign sm[i]         = 1'b0;
          assign cry[s][c][i]  = 1'b0;
        end
      end

      // Next column content: untouched bits, then sums, then carries from c-1.
      for (genvar k = 0; k < WIDTH; k++) begin : g_out
        if (k < P) begin : g_pass
          assign bits[s+1][c][k] = bits[s][c][3*NF+2*NH+k];
        end else if (k < P + NF + NH) begin : g_sum
          assign bits[s+1][c][k] = sm[k-P];
        end else if (k < P + NF + NH + KIN) begin : g_cin
          assign bits[s+1][c][k] = cry[s][c-1][k-P-NF-NH];
        end else begin : g_z
          assign bits[s+1][c][k] = 1'b0;
        end
      end

      logic unused_sink;
      assign unused_sink = ^{bits[s][c], cry[s][c], sm};
    end
  end
endmodule

// File: rtl/dadda_reduce_pipe.sv
// Two-stage pipelined Dadda front end: S1 operand capture, S2 reduced rows,
// with a stall-propagating valid/ready handshake.
module dadda_reduce_pipe import dadda_pkg::*; #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] row_a,
  output logic [2*WIDTH-1:0] row_b
);
  logic               s1_valid, s1_apx;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [2*WIDTH-1:0] tree_a, tree_b;
  logic               s1_adv, s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  dadda_tree #(.WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS)) u_tree (
    .a(s1_a), .b(s1_b), .approx_en(s1_apx), .row_a(tree_a), .row_b(tree_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_apx   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in1;
        s1_b   <= in2;
        s1_apx <= approx_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      row_a     <= '0;
      row_b     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        row_a <= tree_a;
        row_b <= tree_b;
      end
    end
  end
endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Self-checking bench for dadda_reduce_pipe (WIDTH=8, APPROX_COLS=4): table
// vectors, directed pipeline sequences and a randomized scoreboard run.
module tb_dadda_reduce_pipe;
  localparam int W = 8;
  localparam int K = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, approx_en = 1'b0, out_valid, out_ready = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [2*W-1:0] row_a, row_b;
  logic [2*W-1:0] sum16;

  always #5 clk = ~clk;
  assign sum16 = row_a + row_b;

  dadda_reduce_pipe #(.WIDTH(W), .APPROX_COLS(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .row_a(row_a), .row_b(row_b)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         ap;
    int unsigned  sum;
  } vec_t;

  int ncmp = 0, nfail = 0;
  int acc_cnt = 0, out_cnt = 0;
  vec_t q[$];
  logic use_tab = 1'b0;
  int unsigned tab_val = 0;
  logic hold = 1'b0;
  logic [2*W-1:0] hold_a, hold_b;

  // Column-wise reference: exact columns weigh their popcount, approximated ones their OR.
  function automatic int unsigned ref_model(logic [W-1:0] a, logic [W-1:0] b, logic ap);
    int unsigned s;
    int cnt;
    if (!ap) return (a * b) & 32'hFFFF;
    s = 0;
    for (int c = 0; c < 2*W-1; c++) begin
      cnt = 0;
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j == c && a[j] && b[i]) cnt++;
      if (c < K) s += ((cnt != 0) ? 1 : 0) << c;
      else       s += cnt << c;
    end
    return s & 32'hFFFF;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: observe handshakes just before the edge, then return 1 unit after it.
  task automatic cyc();
    vec_t e;
    @(negedge clk);
    if (!rst) begin
      if (hold) begin
        check("stall_row_a", row_a, hold_a);
        check("stall_row_b", row_b, hold_b);
      end
      hold   = out_valid && !out_ready;
      hold_a = row_a;
      hold_b = row_b;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("sum", sum16, e.sum);
          if (e.ap) check("approx_rowb_low", row_b[K-1:0], 0);
          out_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        e.a = in1; e.b = in2; e.ap = approx_en;
        e.sum = use_tab ? tab_val : ref_model(in1, in2, approx_en);
        q.push_back(e);
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pair();
    in1 = W'($urandom);
    in2 = W'($urandom);
    approx_en = $urandom_range(0, 1) == 1;
  endtask

  vec_t tab[8];
  int a0, o0, n;
  logic [6:0] vpat;
  logic [2*W-1:0] sa, sb;

  initial begin
    tab[0] = '{8'hFF, 8'hFF, 1'b0, 65025};
    tab[1] = '{8'h0F, 8'h0F, 1'b1, 191};
    tab[2] = '{8'h0F, 8'h0F, 1'b0, 225};
    tab[3] = '{8'hFF, 8'hFF, 1'b1, 64991};
    tab[4] = '{8'hAB, 8'hCD, 1'b0, 35055};
    tab[5] = '{8'h00, 8'hFF, 1'b1, 0};
    tab[6] = '{8'h01, 8'h01, 1'b1, 1};
    tab[7] = '{8'h80, 8'h80, 1'b1, 16384};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_row_a", row_a, 0);
    check("rst_row_b", row_b, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // Table vectors: captured into S1 at the accept edge, rows valid after the next.
    foreach (tab[i]) begin
      in1 = tab[i].a; in2 = tab[i].b; approx_en = tab[i].ap;
      in_valid = 1'b1; out_ready = 1'b1; use_tab = 1'b1; tab_val = tab[i].sum;
      o0 = out_cnt;
      cyc();
      in_valid = 1'b0; use_tab = 1'b0;
      check("lat_early", out_valid, 0);
      cyc();
      check("lat_valid", out_valid, 1);
      n = 0;
      while (out_cnt == o0 && n < 10) begin cyc(); n++; end
      check("tab_done", out_cnt - o0, 1);
    end

    // Back-to-back: 4 pairs, 4 consecutive valid cycles
    o0 = out_cnt;
    for (int t = 0; t < 7; t++) begin
      in_valid = (t < 4);
      rand_pair();
      cyc();
      vpat[t] = out_valid;
    end
    check("b2b_valid_pattern", vpat, 7'b0011110);
    check("b2b_count", out_cnt - o0, 4);

    // Backpressure: only 2 of 3 accepted, rows frozen, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; rand_pair();
    a0 = acc_cnt; o0 = out_cnt;
    for (int t = 0; t < 5; t++) begin
      n = acc_cnt;
      cyc();
      if (acc_cnt != n) rand_pair();
    end
    check("bp_accepted", acc_cnt - a0, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    sa = row_a; sb = row_b;
    cyc(); cyc();
    check("bp_hold_a", row_a, sa);
    check("bp_hold_b", row_b, sb);
    out_ready = 1'b1;
    n = 0;
    while ((out_cnt - o0 < 3) && n < 20) begin
      cyc();
      if (acc_cnt - a0 >= 3) in_valid = 1'b0;
      n++;
    end
    check("bp_drained", out_cnt - o0, 3);
    check("bp_queue_empty", q.size(), 0);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    rand_pair(); cyc();
    rand_pair(); cyc();
    in_valid = 1'b0;
    check("pre_rst_full", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    q.delete();
    hold = 1'b0;
    cyc();
    rst = 1'b0;
    check("rst_rel_in_ready", in_ready, 1);
    out_ready = 1'b1;
    vpat = '0;
    for (int t = 0; t < 5; t++) begin cyc(); vpat[t] = out_valid; end
    check("no_stale", vpat, 0);

    // Randomized run against the reference model
    a0 = acc_cnt; n = 0;
    while (acc_cnt - a0 < 10000 && n < 60000) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      rand_pair();
      cyc();
      n++;
    end
    check("rand_accepted", acc_cnt - a0, 10000);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin cyc(); n++; end
    check("rand_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
